// File: rtl/io_bridge.sv
// Memory/IO bridge: address pass-through, read-data steering, and a small IO window
// with synchronised input channels, sticky change flags and read-back output channels.
module io_bridge #(
  parameter int              NUM_IN    = 2,
  parameter int              NUM_OUT   = 2,
  parameter int              CH_W      = 16,
  parameter logic [31:0]     IO_BASE   = 32'hFFFFFC00,
  parameter logic [CH_W-1:0] RESET_OUT = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mRead,
  input  logic                    mWrite,
  input  logic                    ioRead,
  input  logic                    ioWrite,
  input  logic [31:0]             addr_in,
  input  logic [31:0]             Mdata,
  input  logic [31:0]             Rdata,
  input  logic [NUM_IN*CH_W-1:0]  in_data,
  output logic [31:0]             addr,
  output logic [31:0]             r_data,
  output logic [31:0]             w_data,
  output logic [NUM_OUT*CH_W-1:0] out_data,
  output logic                    io_err,
  output logic                    irq
);

  localparam int IW = NUM_IN * CH_W;
  localparam int OW = NUM_OUT * CH_W;

  logic [IW-1:0]     r_sync1;
  logic [IW-1:0]     r_sync2;
  logic [IW-1:0]     r_prev;
  logic [NUM_IN-1:0] r_status;
  logic [1:0]        r_arm;
  logic [OW-1:0]     r_out;
  logic              r_io_err;

  logic              w_win;
  logic [7:0]        w_off;
  logic [4:0]        w_idx;
  logic              w_aligned;
  logic              w_is_in;
  logic              w_is_out;
  logic              w_is_stat;
  logic              w_unmapped;
  logic [31:0]       w_io_rd;
  logic [NUM_IN-1:0] w_chg;
  logic [NUM_IN-1:0] w_clr;
  logic              w_unused;

  // mRead selects nothing here: Mdata is already the default read source.
  assign w_unused = mRead;

  assign w_win      = (addr_in[31:8] == IO_BASE[31:8]);
  assign w_off      = addr_in[7:0];
  assign w_idx      = {1'b0, w_off[5:2]};
  assign w_aligned  = (w_off[1:0] == 2'b00);
  assign w_is_in    = w_win && w_aligned && (w_off[7:6] == 2'b00) && (w_idx < 5'(NUM_IN));
  assign w_is_out   = w_win && w_aligned && (w_off[7:6] == 2'b01) && (w_idx < 5'(NUM_OUT));
  assign w_is_stat  = w_win && (w_off == 8'h80);
  assign w_unmapped = !(w_is_in || w_is_out || w_is_stat);

  always_comb begin
    w_io_rd = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_is_in && (w_idx == 5'(i))) w_io_rd[CH_W-1:0] = r_sync2[i*CH_W +: CH_W];
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      if (w_is_out && (w_idx == 5'(j))) w_io_rd[CH_W-1:0] = r_out[j*CH_W +: CH_W];
    end
    if (w_is_stat) w_io_rd[NUM_IN-1:0] = r_status;
  end

  // Flags only fire once the arm counter saturates, so reset-to-live input edges are ignored.
  always_comb begin
    w_chg = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_chg[i] = (r_sync2[i*CH_W +: CH_W] != r_prev[i*CH_W +: CH_W]) && (r_arm == 2'd3);
    end
  end

  assign w_clr = (ioWrite && w_is_stat) ? Rdata[NUM_IN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_prev   <= '0;
      r_status <= '0;
      r_arm    <= 2'd0;
      r_out    <= {NUM_OUT{RESET_OUT}};
      r_io_err <= 1'b0;
    end else begin
      r_sync1  <= in_data;
      r_sync2  <= r_sync1;
      r_prev   <= r_sync2;
      if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
      // A new change outranks a simultaneous write-1-to-clear.
      r_status <= (r_status & ~w_clr) | w_chg;
      r_io_err <= (ioRead || ioWrite) && w_unmapped;
      for (int j = 0; j < NUM_OUT; j++) begin
        if (ioWrite && w_is_out && (w_idx == 5'(j))) r_out[j*CH_W +: CH_W] <= Rdata[CH_W-1:0];
      end
    end
  end

  assign addr     = addr_in;
  assign w_data   = mWrite ? Rdata : 32'd0;
  assign r_data   = ioRead ? w_io_rd : Mdata;
  assign out_data = r_out;
  assign io_err   = r_io_err;
  assign irq      = |r_status;

endmodule
